// File: rtl/ddr3_port_arbiter_pkg.sv
// ddr3_arb_pkg: shared types and defaults for the DDR3 port arbiter.
//   req_id_t             - requester identifier (0 = write path, 1 = read path)
//   cr_ctrl_t            - control half of the command register (valid/id/rnw)
//   ARB_MAX_OUTSTANDING  - default read-tag FIFO depth
//   ARB_GRANT_HOLD       - default max consecutive grants under contention
package ddr3_arb_pkg;

    typedef logic req_id_t;

    typedef struct packed {
        logic    valid;
        req_id_t id;
        logic    rnw;
    } cr_ctrl_t;

    localparam int unsigned ARB_MAX_OUTSTANDING = 16;
    localparam int unsigned ARB_GRANT_HOLD      = 4;

    function automatic req_id_t other_req(input req_id_t id);
        return ~id;
    endfunction

endpackage

// File: rtl/ddr3_port_arbiter_if.sv
// ddr3_port_arbiter_if: requester-side and Avalon-side bus of the arbiter.
//   Requester side: req, rnw, addr0/1, wdata0/1 in; ack, rvalid, rdata out.
//   Avalon side   : avl_addr, avl_read_req, avl_write_req, avl_wdata out;
//                   avl_ready, avl_rdata_valid, avl_rdata in.
//   slave  modport: the arbiter's view.
//   master modport: the view of the surrounding engines / controller.
interface ddr3_port_arbiter_if #(
    parameter int unsigned ADDR_W = 30,
    parameter int unsigned DATA_W = 512
);
    logic [1:0]        req;
    logic [1:0]        rnw;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic [1:0]        ack;
    logic [1:0]        rvalid;
    logic [DATA_W-1:0] rdata;

    logic [ADDR_W-1:0] avl_addr;
    logic              avl_read_req;
    logic              avl_write_req;
    logic [DATA_W-1:0] avl_wdata;
    logic              avl_ready;
    logic              avl_rdata_valid;
    logic [DATA_W-1:0] avl_rdata;

    modport slave (
        input  req, rnw, addr0, addr1, wdata0, wdata1,
               avl_ready, avl_rdata_valid, avl_rdata,
        output ack, rvalid, rdata,
               avl_addr, avl_read_req, avl_write_req, avl_wdata
    );

    modport master (
        output req, rnw, addr0, addr1, wdata0, wdata1,
               avl_ready, avl_rdata_valid, avl_rdata,
        input  ack, rvalid, rdata,
               avl_addr, avl_read_req, avl_write_req, avl_wdata
    );
endinterface

// File: rtl/ddr3_port_arbiter_tag_fifo.sv
// ddr3_arb_tag_fifo: synchronous FIFO of requester ids for in-flight reads.
//   clk_i, rst_ni      - clock, asynchronous active-low reset
//   push_i, push_id_i  - enqueue id (ignored when full)
//   pop_i              - dequeue head (ignored when empty)
//   head_id_o          - id at the head
//   count_o            - occupancy, 0..DEPTH
//   empty_o, full_o    - status
// Pointers carry one extra wrap bit; full/empty are resolved by the MSBs.
module ddr3_arb_tag_fifo
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned DEPTH = ARB_MAX_OUTSTANDING
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   push_i,
    input  req_id_t                push_id_i,
    input  logic                   pop_i,
    output req_id_t                head_id_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   empty_o,
    output logic                   full_o
);
    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0] wr_q, wr_d;
    logic [AW:0] rd_q, rd_d;
    req_id_t     mem_q [DEPTH];
    logic        do_push;
    logic        do_pop;

    assign empty_o   = (wr_q == rd_q);
    assign full_o    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
    assign count_o   = wr_q - rd_q;
    assign head_id_o = mem_q[rd_q[AW-1:0]];
    assign do_push   = push_i & ~full_o;
    assign do_pop    = pop_i & ~empty_o;

    always_comb begin
        wr_d = do_push ? wr_q + 1'b1 : wr_q;
        rd_d = do_pop  ? rd_q + 1'b1 : rd_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_q[AW-1:0]] <= push_id_i;
    end
endmodule

// File: rtl/ddr3_port_arbiter.sv
// ddr3_port_arbiter: shares one Avalon-MM DDR3 port between requester 0
// (host-load writes) and requester 1 (buffer/correction reads).
//   clk, rstb        - clock, asynchronous active-low reset
//   enable           - permit new grants
//   bus (slave)      - requester commands/acks/read returns and Avalon port
//   idle             - no held command and no outstanding reads
//   err_orphan       - sticky: read data arrived with no outstanding tag
//   stat_grants0/1, stat_stall - saturating counters when the macro
//                      DDR3_ARB_STATS_EN is defined, otherwise tied to 0
// Single-entry command register drives Avalon directly; round-robin with
// bounded hold; a tag FIFO routes read beats back to their issuer.
module ddr3_port_arbiter
    import ddr3_arb_pkg::*;
#(
    parameter int unsigned ADDR_W          = 30,
    parameter int unsigned DATA_W          = 512,
    parameter int unsigned MAX_OUTSTANDING = ARB_MAX_OUTSTANDING,
    parameter int unsigned GRANT_HOLD      = ARB_GRANT_HOLD
) (
    input  logic                clk,
    input  logic                rstb,
    input  logic                enable,
    ddr3_port_arbiter_if.slave  bus,
    output logic                idle,
    output logic                err_orphan,
    output logic [31:0]         stat_grants0,
    output logic [31:0]         stat_grants1,
    output logic [31:0]         stat_stall
);
    localparam int unsigned CW = $clog2(MAX_OUTSTANDING) + 1;

    cr_ctrl_t          cr_q, cr_d;
    logic [ADDR_W-1:0] cr_addr_q, cr_addr_d;
    logic [DATA_W-1:0] cr_wdata_q, cr_wdata_d;
    req_id_t           ptr_q, ptr_d;
    logic [31:0]       hold_q, hold_d;
    logic [1:0]        rvalid_q, rvalid_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic              err_q, err_d;

    logic              accept, room, pending, rd_room;
    logic [1:0]        elig;
    logic              gnt_vld;
    req_id_t           gnt_id;
    logic [1:0]        ack;
    logic [31:0]       run;

    logic              fifo_push, fifo_pop, fifo_empty, fifo_full;
    req_id_t           fifo_head;
    logic [CW-1:0]     fifo_count;

    ddr3_arb_tag_fifo #(.DEPTH(MAX_OUTSTANDING)) u_tag_fifo (
        .clk_i     (clk),
        .rst_ni    (rstb),
        .push_i    (fifo_push),
        .push_id_i (cr_q.id),
        .pop_i     (fifo_pop),
        .head_id_o (fifo_head),
        .count_o   (fifo_count),
        .empty_o   (fifo_empty),
        .full_o    (fifo_full)
    );

    // A read sitting in CR will push on accept, so it already holds a slot.
    always_comb begin
        accept  = cr_q.valid & bus.avl_ready;
        room    = ~cr_q.valid | accept;
        pending = cr_q.valid & cr_q.rnw;
        rd_room = ~fifo_full & ((32'(fifo_count) + 32'(pending)) < MAX_OUTSTANDING);
        for (int unsigned i = 0; i < 2; i++) begin
            elig[i] = bus.req[i] & enable & room & (~bus.rnw[i] | rd_room);
        end
        gnt_vld = |elig;
        gnt_id  = elig[ptr_q] ? ptr_q : other_req(ptr_q);
        ack     = '0;
        if (gnt_vld && rstb) ack[gnt_id] = 1'b1;
    end

    // run = grants already given to the pointer holder while contested;
    // the pointer flips once that reaches GRANT_HOLD.
    always_comb begin
        ptr_d  = ptr_q;
        hold_d = hold_q;
        run    = '0;
        if (gnt_vld) begin
            if (gnt_id == ptr_q && bus.req[other_req(gnt_id)]) run = hold_q;
            if (run >= GRANT_HOLD - 1) begin
                ptr_d  = other_req(gnt_id);
                hold_d = '0;
            end else begin
                ptr_d  = gnt_id;
                hold_d = run + 32'd1;
            end
        end
    end

    always_comb begin
        cr_d       = cr_q;
        cr_addr_d  = cr_addr_q;
        cr_wdata_d = cr_wdata_q;
        if (gnt_vld) begin
            cr_d.valid = 1'b1;
            cr_d.id    = gnt_id;
            cr_d.rnw   = bus.rnw[gnt_id];
            cr_addr_d  = gnt_id ? bus.addr1  : bus.addr0;
            cr_wdata_d = gnt_id ? bus.wdata1 : bus.wdata0;
        end else if (accept) begin
            cr_d.valid = 1'b0;
        end
    end

    always_comb begin
        fifo_push = accept & cr_q.rnw;
        fifo_pop  = bus.avl_rdata_valid & ~fifo_empty;
        rvalid_d  = '0;
        rdata_d   = rdata_q;
        err_d     = err_q | (bus.avl_rdata_valid & fifo_empty);
        if (fifo_pop) begin
            rvalid_d[fifo_head] = 1'b1;
            rdata_d             = bus.avl_rdata;
        end
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            cr_q       <= '0;
            cr_addr_q  <= '0;
            cr_wdata_q <= '0;
            ptr_q      <= 1'b0;
            hold_q     <= '0;
            rvalid_q   <= '0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            cr_q       <= cr_d;
            cr_addr_q  <= cr_addr_d;
            cr_wdata_q <= cr_wdata_d;
            ptr_q      <= ptr_d;
            hold_q     <= hold_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign bus.ack           = ack;
    assign bus.rvalid        = rvalid_q;
    assign bus.rdata         = rdata_q;
    assign bus.avl_addr      = cr_addr_q;
    assign bus.avl_wdata     = cr_wdata_q;
    assign bus.avl_read_req  = cr_q.valid & cr_q.rnw;
    assign bus.avl_write_req = cr_q.valid & ~cr_q.rnw;
    assign idle              = ~cr_q.valid & (fifo_count == '0);
    assign err_orphan        = err_q;

`ifdef DDR3_ARB_STATS_EN
    logic [31:0] g0_q, g0_d, g1_q, g1_d, st_q, st_d;

    always_comb begin
        g0_d = (ack[0] && g0_q != '1) ? g0_q + 32'd1 : g0_q;
        g1_d = (ack[1] && g1_q != '1) ? g1_q + 32'd1 : g1_q;
        st_d = (cr_q.valid && !bus.avl_ready && st_q != '1) ? st_q + 32'd1 : st_q;
    end

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            g0_q <= '0;
            g1_q <= '0;
            st_q <= '0;
        end else begin
            g0_q <= g0_d;
            g1_q <= g1_d;
            st_q <= st_d;
        end
    end

    assign stat_grants0 = g0_q;
    assign stat_grants1 = g1_q;
    assign stat_stall   = st_q;
`else
    assign stat_grants0 = '0;
    assign stat_grants1 = '0;
    assign stat_stall   = '0;
`endif
endmodule

// File: tb/tb_ddr3_port_arbiter.sv
// tb_ddr3_port_arbiter: directed scenarios plus a randomized run, checked
// every cycle against a command-level reference model of the arbiter.
module tb_ddr3_port_arbiter;
    localparam int AW = 30;
    localparam int DW = 512;
    localparam int MO = 16;
    localparam int GH = 4;

    logic        clk = 1'b0;
    logic        rstb;
    logic        enable;
    logic        idle;
    logic        err_orphan;
    logic [31:0] sg0, sg1, sst;

    ddr3_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ddr3_port_arbiter #(
        .ADDR_W(AW), .DATA_W(DW), .MAX_OUTSTANDING(MO), .GRANT_HOLD(GH)
    ) dut (
        .clk(clk), .rstb(rstb), .enable(enable), .bus(bus),
        .idle(idle), .err_orphan(err_orphan),
        .stat_grants0(sg0), .stat_grants1(sg1), .stat_stall(sst)
    );

    initial forever #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference model state (command level)
    bit              m_crv;
    int              m_crid;
    bit              m_crrnw;
    logic [AW-1:0]   m_craddr;
    logic [DW-1:0]   m_crwdata;
    int              q[$];
    int              fav, streak;
    logic [1:0]      m_rvalid;
    logic [DW-1:0]   m_rdata;
    bit              m_err;
    longint          e_g0, e_g1, e_st;
    logic [1:0]      seen_ack;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] rnd();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic longint sat(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    function automatic logic [31:0] stat_exp(input longint v);
`ifdef DDR3_ARB_STATS_EN
        return v[31:0];
`else
        return (v == 0) ? 32'd0 : 32'd0;
`endif
    endfunction

    task automatic model_reset();
        m_crv = 0; m_crid = 0; m_crrnw = 0; m_craddr = '0; m_crwdata = '0;
        q.delete(); fav = 0; streak = 0; m_rvalid = '0; m_rdata = '0; m_err = 0;
        e_g0 = 0; e_g1 = 0; e_st = 0;
    endtask

    task automatic quiet_inputs();
        bus.req = '0; bus.rnw = '0; bus.avl_ready = 1'b1;
        bus.avl_rdata_valid = 1'b0; enable = 1'b1;
    endtask

    task automatic rand_inputs();
        bus.req = 2'($urandom); bus.rnw = 2'($urandom);
        bus.addr0 = AW'($urandom); bus.addr1 = AW'($urandom);
        bus.wdata0 = rnd(); bus.wdata1 = rnd();
        enable = ($urandom_range(0, 9) != 0);
        bus.avl_ready = ($urandom_range(0, 3) != 0);
        bus.avl_rdata_valid = (q.size() > 0) && ($urandom_range(0, 2) == 0);
        bus.avl_rdata = rnd();
    endtask

    // One clock: settle inputs, compare every output with the model, advance
    // the model, then move to just after the next rising edge.
    task automatic cycle();
        bit         accept, room;
        int         inflight, w, id;
        bit [1:0]   el;
        logic [1:0] ea;
        #1;
        accept   = m_crv && bus.avl_ready;
        room     = !m_crv || accept;
        inflight = q.size() + ((m_crv && m_crrnw) ? 1 : 0);
        for (int i = 0; i < 2; i++)
            el[i] = bus.req[i] && enable && room && (!bus.rnw[i] || inflight < MO);
        w = -1;
        if (el[fav]) w = fav;
        else if (el[1-fav]) w = 1 - fav;
        ea = '0;
        if (w >= 0) ea[w] = 1'b1;
        seen_ack = bus.ack;

        chk("ack", bus.ack, ea);
        chk("avl_read_req", bus.avl_read_req, m_crv && m_crrnw);
        chk("avl_write_req", bus.avl_write_req, m_crv && !m_crrnw);
        chk("avl_addr", bus.avl_addr, m_craddr);
        chk("avl_wdata", bus.avl_wdata, m_crwdata);
        chk("rvalid", bus.rvalid, m_rvalid);
        chk("rdata", bus.rdata, m_rdata);
        chk("idle", idle, !m_crv && q.size() == 0);
        chk("err_orphan", err_orphan, m_err);
        chk("stat_grants0", sg0, stat_exp(e_g0));
        chk("stat_grants1", sg1, stat_exp(e_g1));
        chk("stat_stall", sst, stat_exp(e_st));

        if (w >= 0) begin
            if (w != fav || !bus.req[1-w]) streak = 0;
            streak++;
            if (streak >= GH) begin fav = 1 - w; streak = 0; end
            else fav = w;
            if (w == 0) e_g0 = sat(e_g0); else e_g1 = sat(e_g1);
        end
        if (m_crv && !bus.avl_ready) e_st = sat(e_st);
        m_rvalid = '0;
        if (bus.avl_rdata_valid) begin
            if (q.size() > 0) begin
                id = q.pop_front();
                m_rvalid[id] = 1'b1;
                m_rdata = bus.avl_rdata;
            end else m_err = 1;
        end
        if (accept && m_crrnw) q.push_back(m_crid);
        if (w >= 0) begin
            m_crv = 1; m_crid = w; m_crrnw = bus.rnw[w];
            m_craddr  = w ? bus.addr1 : bus.addr0;
            m_crwdata = w ? bus.wdata1 : bus.wdata0;
        end else if (accept) m_crv = 0;
        @(posedge clk); #1;
    endtask

    task automatic drain();
        quiet_inputs();
        for (int k = 0; k < 100 && (q.size() > 0 || m_crv); k++) begin
            bus.avl_rdata_valid = (q.size() > 0);
            bus.avl_rdata = rnd();
            cycle();
        end
        bus.avl_rdata_valid = 1'b0;
        chk("drained_idle", idle, 1'b1);
    endtask

    task automatic chk_reset();
        chk("rst_ack", bus.ack, 2'b00);
        chk("rst_rvalid", bus.rvalid, 2'b00);
        chk("rst_rdata", bus.rdata, '0);
        chk("rst_avl_addr", bus.avl_addr, '0);
        chk("rst_avl_wdata", bus.avl_wdata, '0);
        chk("rst_avl_read_req", bus.avl_read_req, 1'b0);
        chk("rst_avl_write_req", bus.avl_write_req, 1'b0);
        chk("rst_idle", idle, 1'b1);
        chk("rst_err_orphan", err_orphan, 1'b0);
        chk("rst_stats", {sg0, sg1, sst}, '0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] d;
        logic [AW-1:0] a_snap;
        logic [DW-1:0] w_snap;
        int ids[5];
        int route_exp[6];
        ids = '{1, 0, 1, 1, 0};
        route_exp = '{1, 0, 1, 1, 0, 0};

        rstb = 1'b0;
        quiet_inputs();
        bus.addr0 = '0; bus.addr1 = '0; bus.wdata0 = '0; bus.wdata1 = '0;
        bus.avl_rdata = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk_reset();
        @(negedge clk) rstb = 1'b1;
        @(posedge clk); #1;

        // contention: both write continuously
        bus.req = 2'b11; bus.rnw = 2'b00;
        for (int k = 0; k < 8; k++) begin
            bus.addr0 = AW'($urandom); bus.addr1 = AW'($urandom);
            bus.wdata0 = rnd(); bus.wdata1 = rnd();
            cycle();
            chk("cont_grant", seen_ack, (k < 4) ? 2'b01 : 2'b10);
            chk("cont_busy", bus.avl_write_req, 1'b1);
        end

        // backpressure with a write held
        bus.req = 2'b01; bus.avl_ready = 1'b0;
        a_snap = m_craddr; w_snap = m_crwdata;
        for (int k = 0; k < 10; k++) begin
            cycle();
            chk("bp_ack", seen_ack, 2'b00);
            chk("bp_addr", bus.avl_addr, a_snap);
            chk("bp_wdata", bus.avl_wdata, w_snap);
        end
`ifdef DDR3_ARB_STATS_EN
        chk("bp_stall", sst, 32'd10);
`else
        chk("bp_stall", sst, 32'd0);
`endif
        drain();

        // single read
        bus.req = 2'b10; bus.rnw = 2'b10; bus.addr1 = AW'('h100);
        cycle();
        chk("sr_ack", seen_ack, 2'b10);
        bus.req = 2'b00;
        chk("sr_read_req", bus.avl_read_req, 1'b1);
        chk("sr_addr", bus.avl_addr, 'h100);
        repeat (5) cycle();
        d = rnd();
        bus.avl_rdata_valid = 1'b1; bus.avl_rdata = d;
        cycle();
        bus.avl_rdata_valid = 1'b0;
        chk("sr_rvalid", bus.rvalid, 2'b10);
        chk("sr_rdata", bus.rdata, d);
        cycle();
        chk("sr_idle", idle, 1'b1);

        // outstanding limit
        bus.req = 2'b10; bus.rnw = 2'b10;
        for (int k = 0; k < MO; k++) begin
            bus.addr1 = AW'($urandom);
            cycle();
            chk("ol_ack", seen_ack, 2'b10);
        end
        repeat (2) begin
            cycle();
            chk("ol_full", seen_ack, 2'b00);
        end
        bus.req = 2'b11; bus.addr0 = AW'($urandom); bus.wdata0 = rnd();
        cycle();
        chk("ol_write", seen_ack, 2'b01);
        bus.req = 2'b10; bus.avl_rdata_valid = 1'b1; bus.avl_rdata = rnd();
        cycle();
        chk("ol_blocked", seen_ack, 2'b00);
        bus.avl_rdata_valid = 1'b0;
        cycle();
        chk("ol_resume", seen_ack, 2'b10);
        drain();

        // routing: reads 1,0,1,1,0 then returns overlapping a 6th read
        bus.rnw = 2'b11;
        for (int k = 0; k < 5; k++) begin
            bus.req = (ids[k] == 1) ? 2'b10 : 2'b01;
            bus.addr0 = AW'($urandom); bus.addr1 = AW'($urandom);
            cycle();
        end
        bus.req = 2'b01;
        for (int k = 0; k < 6; k++) begin
            bus.avl_rdata_valid = 1'b1; bus.avl_rdata = rnd();
            cycle();
            bus.req = 2'b00;
            chk("route_rvalid", bus.rvalid, (route_exp[k] == 1) ? 2'b10 : 2'b01);
            chk("route_idle", idle, k == 5);
        end
        bus.avl_rdata_valid = 1'b0;

        // randomized traffic
        for (int k = 0; k < 1500; k++) begin
            rand_inputs();
            cycle();
        end
        drain();

        // orphan return
        bus.avl_rdata_valid = 1'b1; bus.avl_rdata = rnd();
        cycle();
        bus.avl_rdata_valid = 1'b0;
        chk("orphan_err", err_orphan, 1'b1);
        chk("orphan_rvalid", bus.rvalid, 2'b00);

        // reset in the middle of traffic
        for (int k = 0; k < 20; k++) begin
            rand_inputs();
            cycle();
        end
        rand_inputs();
        bus.req = 2'b11;
        #2 rstb = 1'b0;
        #1;
        model_reset();
        chk_reset();
        quiet_inputs();
        @(negedge clk) rstb = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < 40; k++) begin
            rand_inputs();
            cycle();
        end
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ddr3_port_arbiter.md
# ddr3_port_arbiter

Shares the single Avalon-MM DDR3 port between two requesters: requester 0 (host-load write path, DDR3_WRITE mode) and requester 1 (buffer/correction read path, DDR3_READ mode). It sits between the PSL-side engines and the DDR3 controller. It arbitrates single-beat commands round-robin with bounded hold, limits outstanding reads, and routes each read-return beat back to the requester that issued it.

## Interface
- ADDR_W, 30, Avalon word address width
- DATA_W, 512, data width
- MAX_OUTSTANDING, 16, read-tag FIFO depth; power of 2, ≥2
- GRANT_HOLD, 4, max consecutive grants to one requester while the other is requesting
- clk  in  1  ha_pclock domain clock
- rstb  in  1  asynchronous active-low reset
- enable  in  1  permit new grants
- req[1:0]  in  2  per-requester command request
- rnw[1:0]  in  2  1 = read, 0 = write
- addr0, addr1  in  ADDR_W each  command address
- wdata0, wdata1  in  DATA_W each  write data
- ack[1:0]  out  2  command captured (one-cycle pulse)
- rvalid[1:0]  out  2  read beat for requester
- rdata  out  DATA_W  read data, shared
- avl_addr  out  ADDR_W
- avl_read_req, avl_write_req  out  1 each
- avl_wdata  out  DATA_W
- avl_ready  in  1
- avl_rdata_valid  in  1
- avl_rdata  in  DATA_W
- idle  out  1  no held command and zero outstanding reads
- err_orphan  out  1  sticky; rdata_valid arrived with tag FIFO empty
- stat_grants0, stat_grants1, stat_stall  out  32 each  (see Configuration)

## Operation
- Command register (CR) is one entry: valid, id, rnw, addr, wdata. Avalon outputs come straight from CR flops.
- CR accepts a new command when (~CR.valid | accept), where accept = CR.valid & avl_ready. The read_req or write_req of CR is held stable until accept.
- Eligible requester: req[i] & enable & capture-allowed, and, if rnw[i], (outstanding + pending_push) < MAX_OUTSTANDING.
- Arbitration is round-robin. The pointer moves to the other requester after a grant unless hold_cnt < GRANT_HOLD-1 and the same requester is still eligible. hold_cnt resets when the grantee changes or the other requester is not requesting.
- On a grant, ack[i] pulses in the same cycle and CR loads the command. The requester must present its next command, or deassert req, in the following cycle.
- On accept of a read, id is pushed into the tag FIFO. On avl_rdata_valid, the FIFO pops, rvalid[popped id] is asserted and rdata is registered.
- Simultaneous push and pop leaves the outstanding count unchanged.
- If avl_rdata_valid arrives with the FIFO empty: err_orphan is set, no rvalid is asserted, and the data is discarded.
- enable low blocks new grants only. The held CR command and outstanding reads complete normally.
- idle = ~CR.valid & (outstanding == 0).

## Timing
- Reset values are 0 for: ack, rvalid, rdata, avl_*, CR, FIFO pointers, hold_cnt, err_orphan and stats. idle resets to 1. The round-robin pointer resets to requester 0.
- Request-to-Avalon: req sampled in cycle N gives ack in cycle N and avl_*_req in cycle N+1.
- With avl_ready held high, CR sustains one command per cycle.
- Read return: avl_rdata_valid in cycle M gives rvalid/rdata in cycle M+1.
- Full: when outstanding == MAX_OUTSTANDING, reads are not granted. Writes from either requester still proceed.
- Wrap-around: FIFO pointers are log2(MAX_OUTSTANDING)+1 bits. Full/empty is decided by comparing the MSBs.
- Reset mid-operation clears all state. The DDR3 controller is reset on the same rstb, so in-flight returns are not tracked across reset.

## Configuration
- DDR3_ARB_STATS_EN defined:
  - stat_grants0 and stat_grants1 count acks per requester.
  - stat_stall counts cycles with CR.valid & ~avl_ready.
  - All three saturate at 32'hFFFF_FFFF.
- DDR3_ARB_STATS_EN undefined: the stat ports remain and are tied to 0, and no counter logic is instantiated.

## Structure
- Package ddr3_arb_pkg holds:
  - typedef req_id_t (1 bit);
  - command-register struct type;
  - default constants for MAX_OUTSTANDING and GRANT_HOLD.
- Sub-module ddr3_arb_tag_fifo: synchronous FIFO of req_id_t, MAX_OUTSTANDING deep, with push/pop/count/empty/full.

## Test plan
- Single read: req1=1, rnw1=1, addr1=0x100, avl_ready=1, return after 5 cycles → ack[1] in cycle 0; avl_read_req with avl_addr=0x100 in cycle 1; rvalid[1] one cycle after avl_rdata_valid; idle returns to 1.
- Contention: both requesters continuously request writes, GRANT_HOLD=4 → grant pattern 0,0,0,0,1,1,1,1,… with no idle Avalon cycle.
- Backpressure: avl_ready=0 for 10 cycles with a write held → avl_addr/avl_wdata stable, no further ack, stat_stall=10 (with stats enabled).
- Outstanding limit: 16 reads issued with returns withheld → 17th read not acked; the first return lets it issue the next cycle. A write from requester 0 is still acked while the limit is reached.
- Routing: interleaved reads 1,0,1,1,0 → rvalid order matches exactly; simultaneous push/pop keeps the count.
- Orphan and reset: avl_rdata_valid with the FIFO empty → err_orphan=1, no rvalid. Then assert rstb low mid-burst → all outputs return to reset values and idle=1.
